// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: on-chip tester for CPUTop memory ports.
//   Loads a program image and a data image from a host word stream,
//   releases the CPU with io_run, waits for io_done or a step limit, and then
//   streams a window of data memory back to the host.
// Ports:
//   clock, reset (async, active low)
//   start, cfg_prog_len, cfg_data_len, cfg_rd_start, cfg_rd_end, cfg_step_max
//   in_valid/in_ready/in_data     host image stream
//   out_valid/out_ready/out_data  readback stream
//   busy, seq_done, timeout, step_count  status
//   io_run/io_done                CPU run handshake
//   io_testerProgMem*, io_testerDataMem*, io_testerDataMemDataRead  memory ports
// Optional feature: define SEQ_CHECKSUM_EN to append a running-sum word
//   after the readback window.
module cpu_test_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STEP_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_prog_len,
  input  logic [ADDR_W-1:0] cfg_data_len,
  input  logic [ADDR_W-1:0] cfg_rd_start,
  input  logic [ADDR_W-1:0] cfg_rd_end,
  input  logic [STEP_W-1:0] cfg_step_max,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              seq_done,
  output logic              timeout,
  output logic [STEP_W-1:0] step_count,
  output logic              io_run,
  input  logic              io_done,
  output logic              io_testerProgMemEnable,
  output logic              io_testerProgMemWriteEnable,
  output logic [ADDR_W-1:0] io_testerProgMemAddress,
  output logic [DATA_W-1:0] io_testerProgMemDataWrite,
  output logic              io_testerDataMemEnable,
  output logic              io_testerDataMemWriteEnable,
  output logic [ADDR_W-1:0] io_testerDataMemAddress,
  output logic [DATA_W-1:0] io_testerDataMemDataWrite,
  input  logic [DATA_W-1:0] io_testerDataMemDataRead
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_PROG, S_LOAD_DATA, S_RUN,
    S_RD_ADDR, S_RD_WAIT, S_EMIT, S_FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] prog_len_q, data_len_q, rd_end_q;
  logic [STEP_W-1:0] step_max_q;
  logic [ADDR_W-1:0] load_cnt, rd_ptr;

  logic              prog_beat, data_beat, load_last, rd_last, window_empty;
  logic [STEP_W-1:0] step_next;

`ifdef SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              sum_beat;
`endif

  // Memory strobes are decoded from the state register so that an async
  // reset drops io_run and every write enable without waiting for an edge.
  always_comb begin
    in_ready     = (state == S_LOAD_PROG) || (state == S_LOAD_DATA);
    prog_beat    = (state == S_LOAD_PROG) && in_valid;
    data_beat    = (state == S_LOAD_DATA) && in_valid;
    load_last    = (load_cnt + ADDR_W'(1)) ==
                   ((state == S_LOAD_PROG) ? prog_len_q : data_len_q);
    rd_last      = (rd_ptr + ADDR_W'(1)) == rd_end_q;
    window_empty = rd_ptr >= rd_end_q;
    step_next    = step_count + STEP_W'(1);

    out_valid = (state == S_EMIT);
    busy      = (state != S_IDLE);
    seq_done  = (state == S_FINISH);
    io_run    = (state == S_RUN);

    io_testerProgMemEnable      = prog_beat;
    io_testerProgMemWriteEnable = prog_beat;
    io_testerProgMemAddress     = prog_beat ? load_cnt : '0;
    io_testerProgMemDataWrite   = prog_beat ? in_data : '0;

    io_testerDataMemEnable      = data_beat || (state == S_RD_ADDR);
    io_testerDataMemWriteEnable = data_beat;
    io_testerDataMemAddress     = data_beat ? load_cnt :
                                  ((state == S_RD_ADDR) ? rd_ptr : '0);
    io_testerDataMemDataWrite   = data_beat ? in_data : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      prog_len_q <= '0;
      data_len_q <= '0;
      rd_end_q   <= '0;
      step_max_q <= '0;
      load_cnt   <= '0;
      rd_ptr     <= '0;
      out_data   <= '0;
      timeout    <= 1'b0;
      step_count <= '0;
`ifdef SEQ_CHECKSUM_EN
      sum_q      <= '0;
      sum_beat   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            prog_len_q <= cfg_prog_len;
            data_len_q <= cfg_data_len;
            rd_end_q   <= cfg_rd_end;
            step_max_q <= cfg_step_max;
            rd_ptr     <= cfg_rd_start;
            load_cnt   <= '0;
            timeout    <= 1'b0;
            step_count <= '0;
`ifdef SEQ_CHECKSUM_EN
            sum_q      <= '0;
            sum_beat   <= 1'b0;
`endif
            if (cfg_prog_len != '0)      state <= S_LOAD_PROG;
            else if (cfg_data_len != '0) state <= S_LOAD_DATA;
            else                         state <= S_RUN;
          end
        end
        S_LOAD_PROG: begin
          if (in_valid) begin
            if (load_last) begin
              load_cnt <= '0;
              state    <= (data_len_q != '0) ? S_LOAD_DATA : S_RUN;
            end else begin
              load_cnt <= load_cnt + ADDR_W'(1);
            end
          end
        end
        S_LOAD_DATA: begin
          if (in_valid) begin
            if (load_last) begin
              load_cnt <= '0;
              state    <= S_RUN;
            end else begin
              load_cnt <= load_cnt + ADDR_W'(1);
            end
          end
        end
        S_RUN: begin
          step_count <= step_next;
          // Completion takes priority over the step limit in the same cycle.
          if (io_done || (step_next >= step_max_q)) begin
            if (!io_done) timeout <= 1'b1;
            if (!window_empty) begin
              state <= S_RD_ADDR;
            end else begin
`ifdef SEQ_CHECKSUM_EN
              out_data <= '0;
              sum_beat <= 1'b1;
              state    <= S_EMIT;
`else
              state    <= S_FINISH;
`endif
            end
          end
        end
        S_RD_ADDR: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          out_data <= io_testerDataMemDataRead;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
`ifdef SEQ_CHECKSUM_EN
            if (sum_beat) begin
              state <= S_FINISH;
            end else begin
              sum_q <= sum_q + out_data;
              if (rd_last) begin
                // Checksum beat follows directly, staying in EMIT.
                out_data <= sum_q + out_data;
                sum_beat <= 1'b1;
              end else begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                state  <= S_RD_ADDR;
              end
            end
`else
            if (rd_last) begin
              state <= S_FINISH;
            end else begin
              rd_ptr <= rd_ptr + ADDR_W'(1);
              state  <= S_RD_ADDR;
            end
`endif
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
module tb_cpu_test_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] cfg_prog_len, cfg_data_len, cfg_rd_start, cfg_rd_end;
  logic [31:0] cfg_step_max;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        busy, seq_done, timeout;
  logic [31:0] step_count;
  logic        io_run, io_done;
  logic        pm_en, pm_we, dm_en, dm_we;
  logic [15:0] pm_addr, dm_addr;
  logic [31:0] pm_dw, dm_dw;
  logic [31:0] dm_rd = '0;

  cpu_test_sequencer #(.ADDR_W(16), .DATA_W(32), .STEP_W(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_prog_len(cfg_prog_len), .cfg_data_len(cfg_data_len),
    .cfg_rd_start(cfg_rd_start), .cfg_rd_end(cfg_rd_end),
    .cfg_step_max(cfg_step_max),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .seq_done(seq_done), .timeout(timeout),
    .step_count(step_count), .io_run(io_run), .io_done(io_done),
    .io_testerProgMemEnable(pm_en), .io_testerProgMemWriteEnable(pm_we),
    .io_testerProgMemAddress(pm_addr), .io_testerProgMemDataWrite(pm_dw),
    .io_testerDataMemEnable(dm_en), .io_testerDataMemWriteEnable(dm_we),
    .io_testerDataMemAddress(dm_addr), .io_testerDataMemDataWrite(dm_dw),
    .io_testerDataMemDataRead(dm_rd)
  );

  always #5 clock = ~clock;

  // Memory models behind the tester ports, plus event counters.
  logic [31:0] prog_mem [0:15];
  logic [31:0] data_mem [0:15];
  int prog_wr_cnt = 0, data_wr_cnt = 0, done_cnt = 0, ov_cnt = 0;

  always @(posedge clock) begin
    if (pm_en && pm_we) begin
      prog_mem[pm_addr[3:0]] <= pm_dw;
      prog_wr_cnt++;
    end
    if (dm_en && dm_we) begin
      data_mem[dm_addr[3:0]] <= dm_dw;
      data_wr_cnt++;
    end
    if (dm_en && !dm_we) dm_rd <= data_mem[dm_addr[3:0]];
    if (seq_done) done_cnt++;
    if (out_valid) ov_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] pl, input logic [15:0] dl,
                          input logic [15:0] rs, input logic [15:0] re,
                          input logic [31:0] sm);
    cfg_prog_len = pl; cfg_data_len = dl;
    cfg_rd_start = rs; cfg_rd_end = re; cfg_step_max = sm;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic get_word(input string tag, input logic [31:0] exp,
                          input int stall, input bit chk_lat);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (chk_lat) check({tag, "_latency"}, 64'(n), 64'd2);
    check(tag, 64'(out_data), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check({tag, "_hold"}, {31'd0, out_valid, out_data}, {31'd0, 1'b1, exp});
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic wait_run_end();
    int g;
    g = 0;
    while (!io_run && g < 100) begin @(negedge clock); g++; end
    while (io_run && g < 200) begin @(negedge clock); g++; end
    if (g >= 200) check("run_end_wait", 64'(io_run), 64'd0);
  endtask

  int d0;

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; io_done = 1'b0;
    cfg_prog_len = '0; cfg_data_len = '0; cfg_rd_start = '0;
    cfg_rd_end = '0; cfg_step_max = '0;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_io_run", 64'(io_run), 0);
    check("rst_enables", {60'd0, pm_en, pm_we, dm_en, dm_we}, 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_timeout", 64'(timeout), 0);
    check("rst_step_count", 64'(step_count), 0);
    reset = 1'b1;
    @(negedge clock);

    // T1: load 3 prog + 2 data words with gaps, done after 7 RUN cycles
    d0 = done_cnt;
    do_start(16'd3, 16'd2, 16'd0, 16'd2, 32'd100);
    check("t1_busy", 64'(busy), 1);
    send_word(32'd11); @(negedge clock);
    send_word(32'd22); @(negedge clock);
    send_word(32'd33); @(negedge clock);
    send_word(32'd44); @(negedge clock);
    check("t1_run_before_last", 64'(io_run), 0);
    send_word(32'd55);
    check("t1_run_after_last", 64'(io_run), 1);
    repeat (6) @(negedge clock);
    io_done = 1'b1;
    @(negedge clock);
    io_done = 1'b0;
    check("t1_step_count", 64'(step_count), 64'd7);
    check("t1_timeout", 64'(timeout), 0);
    check("t1_run_dropped", 64'(io_run), 0);
    check("t1_prog0", 64'(prog_mem[0]), 64'd11);
    check("t1_prog1", 64'(prog_mem[1]), 64'd22);
    check("t1_prog2", 64'(prog_mem[2]), 64'd33);
    check("t1_data0", 64'(data_mem[0]), 64'd44);
    check("t1_data1", 64'(data_mem[1]), 64'd55);
    check("t1_prog_writes", 64'(prog_wr_cnt), 64'd3);
    check("t1_data_writes", 64'(data_wr_cnt), 64'd2);
    get_word("t1_rd0", 32'd44, 0, 1'b1);
    get_word("t1_rd1", 32'd55, 0, 1'b1);
`ifdef SEQ_CHECKSUM_EN
    get_word("t1_sum", 32'd99, 0, 1'b0);
`endif
    check("t1_seq_done", 64'(seq_done), 1);
    @(negedge clock);
    check("t1_busy_low", 64'(busy), 0);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);

    // T2: data-only load, step limit 20, readback 0..4 with 3-cycle stalls
    d0 = done_cnt;
    do_start(16'd0, 16'd4, 16'd0, 16'd4, 32'd20);
    send_word(32'hA1);
    send_word(32'hB2); @(negedge clock);
    send_word(32'hC3);
    send_word(32'hD4);
    wait_run_end();
    check("t2_timeout", 64'(timeout), 1);
    check("t2_step_count", 64'(step_count), 64'd20);
    get_word("t2_rd0", 32'hA1, 3, 1'b1);
    get_word("t2_rd1", 32'hB2, 3, 1'b1);
    get_word("t2_rd2", 32'hC3, 3, 1'b1);
    get_word("t2_rd3", 32'hD4, 3, 1'b1);
`ifdef SEQ_CHECKSUM_EN
    get_word("t2_sum", 32'h2EA, 0, 1'b0);
`endif
    repeat (3) @(negedge clock);
    check("t2_done_once", 64'(done_cnt - d0), 64'd1);
    check("t2_timeout_sticky", 64'(timeout), 1);

    // T3: reset asserted during data beat 1
    do_start(16'd1, 16'd3, 16'd0, 16'd1, 32'd5);
    check("t3_timeout_cleared", 64'(timeout), 0);
    send_word(32'h77);
    send_word(32'h88);
    in_valid = 1'b1;
    in_data  = 32'h99;
    #2 reset = 1'b0;
    #1;
    check("t3_rst_dm_en", {62'd0, dm_en, dm_we}, 0);
    check("t3_rst_in_ready", 64'(in_ready), 0);
    check("t3_rst_busy_run", {62'd0, busy, io_run}, 0);
    check("t3_rst_step", 64'(step_count), 0);
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t3_data0_written", 64'(data_mem[0]), 64'h88);
    check("t3_data1_untouched", 64'(data_mem[1]), 64'hB2);
    d0 = done_cnt;
    do_start(16'd2, 16'd1, 16'd0, 16'd2, 32'd5);
    send_word(32'd5);
    send_word(32'd6);
    send_word(32'd7);
    wait_run_end();
    check("t3_timeout", 64'(timeout), 1);
    check("t3_step_count", 64'(step_count), 64'd5);
    check("t3_prog1", 64'(prog_mem[1]), 64'd6);
    get_word("t3_rd0", 32'd7, 1, 1'b1);
    get_word("t3_rd1", 32'hB2, 0, 1'b1);
`ifdef SEQ_CHECKSUM_EN
    get_word("t3_sum", 32'hB9, 0, 1'b0);
`endif
    repeat (2) @(negedge clock);
    check("t3_done_once", 64'(done_cnt - d0), 64'd1);

    // T4: step_max 0 and empty window
    d0 = ov_cnt;
    do_start(16'd0, 16'd0, 16'd3, 16'd3, 32'd0);
    check("t4_cleared", {timeout, step_count}, 0);
    check("t4_run", 64'(io_run), 1);
    @(negedge clock);
    check("t4_step_count", 64'(step_count), 64'd1);
    check("t4_timeout", 64'(timeout), 1);
`ifdef SEQ_CHECKSUM_EN
    get_word("t4_sum", 32'd0, 0, 1'b0);
    check("t4_seq_done", 64'(seq_done), 1);
`else
    check("t4_seq_done", 64'(seq_done), 1);
    repeat (2) @(negedge clock);
    check("t4_no_output", 64'(ov_cnt - d0), 0);
`endif
    repeat (2) @(negedge clock);

    // T5: io_done coincides with step limit -> done wins
    do_start(16'd0, 16'd0, 16'd0, 16'd1, 32'd3);
    repeat (2) @(negedge clock);
    io_done = 1'b1;
    @(negedge clock);
    io_done = 1'b0;
    check("t5_step_count", 64'(step_count), 64'd3);
    check("t5_timeout", 64'(timeout), 0);
    get_word("t5_rd0", 32'd7, 2, 1'b1);
`ifdef SEQ_CHECKSUM_EN
    get_word("t5_sum", 32'd7, 0, 1'b0);
`endif
    repeat (3) @(negedge clock);
    check("t5_idle", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
